// File: rtl/vga_pkg.sv
// Shared constants and the object record for the VGA object arbiter.
package vga_pkg;

  localparam int H_ACT = 640;
  localparam int V_ACT = 480;
  localparam int NOBJ  = 4;

  localparam logic [23:0] BG_COLOR_DEF = 24'h000000;

  // One drawable circle: enable, centre, radius and fill colour.
  typedef struct packed {
    logic        en;
    logic [9:0]  cx;
    logic [9:0]  cy;
    logic [7:0]  r;
    logic [23:0] color;
  } obj_t;

endpackage

// File: rtl/vga_circle_hit.sv
// Hit test for one circle slot.
// Stage 1 registers the squared distances. The compare that follows is
// combinational, so the parent can register the arbitrated result in stage 2.
module vga_circle_hit
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  obj_t        obj,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic        hit,
  output logic [23:0] color
);

  logic [10:0] dx;
  logic [10:0] dy;
  logic [21:0] dx_sq;
  logic [21:0] dy_sq;
  logic [15:0] r_sq;
  logic [21:0] dx2_q;
  logic [21:0] dy2_q;
  logic [15:0] r2_q;
  logic        en_q;
  logic [23:0] color_q;
  logic [21:0] dist2;

  // The differences are signed 11-bit values. Each square is below 2^20,
  // so the low 22 bits of the sign-extended product are exact.
  assign dx    = {1'b0, pix_x} - {1'b0, obj.cx};
  assign dy    = {1'b0, pix_y} - {1'b0, obj.cy};
  assign dx_sq = {{11{dx[10]}}, dx} * {{11{dx[10]}}, dx};
  assign dy_sq = {{11{dy[10]}}, dy} * {{11{dy[10]}}, dy};
  assign r_sq  = {8'b0, obj.r} * {8'b0, obj.r};

  // Stage 1: capture the squared terms with the slot state they were computed from.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dx2_q   <= '0;
      dy2_q   <= '0;
      r2_q    <= '0;
      en_q    <= 1'b0;
      color_q <= '0;
    end else begin
      dx2_q   <= dx_sq;
      dy2_q   <= dy_sq;
      r2_q    <= r_sq;
      en_q    <= obj.en;
      color_q <= obj.color;
    end
  end

  assign dist2 = dx2_q + dy2_q;
  assign hit   = en_q && (dist2 <= {6'b0, r2_q});
  assign color = color_q;

endmodule

// File: rtl/vga_object_arbiter.sv
// Draws up to NOBJ circles over a background colour using fixed priority
// (the lowest slot index wins). Configuration writes are double-buffered:
// each write lands in a pending copy, and the pending copy moves to the
// active copy on frame_start. The block also accumulates per-slot overlap
// flags, which it reports once per frame.
module vga_object_arbiter
  import vga_pkg::obj_t;
  import vga_pkg::BG_COLOR_DEF;
#(
  parameter logic [23:0] BG_COLOR = BG_COLOR_DEF,
  parameter int          NOBJ     = vga_pkg::NOBJ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_start,
  input  logic            pix_valid,
  input  logic [9:0]      pix_x,
  input  logic [9:0]      pix_y,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [1:0]      cfg_id,
  input  logic            cfg_en,
  input  logic [9:0]      cfg_cx,
  input  logic [9:0]      cfg_cy,
  input  logic [7:0]      cfg_r,
  input  logic [23:0]     cfg_color,
  output logic [23:0]     rgb,
  output logic            rgb_valid,
  output logic [NOBJ-1:0] collide
);

  obj_t            pend  [NOBJ];
  obj_t            act   [NOBJ];
  logic [NOBJ-1:0] dirty;
  logic            ready_q;
  logic            accept;
  logic            valid_s1;
  logic [NOBJ-1:0] hit_v;
  logic [23:0]     color_v [NOBJ];
  logic [NOBJ-1:0] hits_s1;
  logic            multi;
  logic [23:0]     win_color;
  logic            found;
  logic [NOBJ-1:0] acc;
  logic [NOBJ-1:0] acc_next;

  // Writes are refused during the commit cycle, so a commit and a write never collide.
  assign cfg_ready = ready_q & ~frame_start;
  assign accept    = cfg_valid & cfg_ready;

  // Ready comes up on the first edge after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_q <= 1'b0;
    else      ready_q <= 1'b1;
  end

  // Slot storage: a write updates the pending copy; frame_start commits dirty slots.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NOBJ; i++) begin
        pend[i] <= '0;
        act[i]  <= '0;
      end
      dirty <= '0;
    end else begin
      if (frame_start) begin
        for (int i = 0; i < NOBJ; i++) begin
          if (dirty[i]) begin
            act[i]   <= pend[i];
            dirty[i] <= 1'b0;
          end
        end
      end
      if (accept) begin
        pend[cfg_id]  <= '{en: cfg_en, cx: cfg_cx, cy: cfg_cy, r: cfg_r, color: cfg_color};
        dirty[cfg_id] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NOBJ; g++) begin : g_slot
    vga_circle_hit u_hit (
      .clk   (clk),
      .rst   (rst),
      .obj   (act[g]),
      .pix_x (pix_x),
      .pix_y (pix_y),
      .hit   (hit_v[g]),
      .color (color_v[g])
    );
  end

  // Carries pix_valid alongside the stage-1 hit terms.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_s1 <= 1'b0;
    else      valid_s1 <= pix_valid;
  end

  // Fixed priority: take the first hitting slot, counting up from slot 0.
  always_comb begin
    win_color = BG_COLOR;
    found     = 1'b0;
    for (int i = 0; i < NOBJ; i++) begin
      if (hit_v[i] && !found) begin
        win_color = color_v[i];
        found     = 1'b1;
      end
    end
  end

  // A pixel with at least two hits marks every slot that hit it.
  assign hits_s1  = valid_s1 ? hit_v : '0;
  assign multi    = |(hits_s1 & (hits_s1 - {{(NOBJ-1){1'b0}}, 1'b1}));
  assign acc_next = acc | (multi ? hits_s1 : '0);

  // Stage 2: register the arbitrated colour. The colour is forced to 0 when no pixel is qualified.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb       <= '0;
      rgb_valid <= 1'b0;
    end else begin
      rgb       <= valid_s1 ? win_color : '0;
      rgb_valid <= valid_s1;
    end
  end

  // The collision accumulator reports on frame_start and then clears. The report includes this cycle's pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      collide <= '0;
    end else if (frame_start) begin
      collide <= acc_next;
      acc     <= '0;
    end else begin
      acc <= acc_next;
    end
  end

endmodule

// File: tb/tb_vga_object_arbiter.sv
// Self-checking bench for vga_object_arbiter: directed scenarios plus a
// randomized run compared against a behavioural model of the drawing rules.
module tb_vga_object_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_id;
  logic        cfg_en;
  logic [9:0]  cfg_cx;
  logic [9:0]  cfg_cy;
  logic [7:0]  cfg_r;
  logic [23:0] cfg_color;
  logic [23:0] rgb;
  logic        rgb_valid;
  logic [3:0]  collide;

  int checks = 0;
  int errors = 0;

  vga_object_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_id      (cfg_id),
    .cfg_en      (cfg_en),
    .cfg_cx      (cfg_cx),
    .cfg_cy      (cfg_cy),
    .cfg_r       (cfg_r),
    .cfg_color   (cfg_color),
    .rgb         (rgb),
    .rgb_valid   (rgb_valid),
    .collide     (collide)
  );

  always #5 clk = ~clk;

  // Behavioural model: each slot is a plain record. The pipeline is two
  // slots of "what the screen should show".
  typedef struct {
    bit          en;
    int          cx;
    int          cy;
    int          r;
    bit [23:0]   color;
  } mobj_t;

  mobj_t       m_pend [4];
  mobj_t       m_act  [4];
  bit          m_dirty [4];
  bit          m_ready;
  bit          s1_v;
  bit [23:0]   s1_rgb;
  bit [3:0]    s1_hits;
  bit [3:0]    m_acc;
  logic [23:0] exp_rgb;
  logic        exp_valid;
  logic [3:0]  exp_collide;
  logic        exp_ready;
  logic        obs_ready;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = '{0, 0, 0, 0, 24'h0};
      m_act[i]  = '{0, 0, 0, 0, 24'h0};
      m_dirty[i] = 0;
    end
    m_ready = 0; s1_v = 0; s1_rgb = 0; s1_hits = 0; m_acc = 0;
    exp_rgb = 0; exp_valid = 0; exp_collide = 0;
  endtask

  // Returns the colour the screen shows at (px,py) and the set of slots that cover the pixel.
  task automatic eval_pixel(input int px, input int py, output bit [23:0] col, output bit [3:0] hits);
    col = 24'h000000;
    hits = 0;
    for (int i = 3; i >= 0; i--) begin
      if (m_act[i].en &&
          (px - m_act[i].cx) * (px - m_act[i].cx) + (py - m_act[i].cy) * (py - m_act[i].cy)
            <= m_act[i].r * m_act[i].r) begin
        hits[i] = 1;
        col = m_act[i].color;
      end
    end
  endtask

  // Drive one cycle of inputs, record pre-edge cfg_ready, advance model and DUT by one clock.
  task automatic step(input bit fs, input bit pv, input int px, input int py,
                      input bit cv, input int id, input bit en, input int cx, input int cy,
                      input int r, input bit [23:0] col);
    bit [23:0] c;
    bit [3:0]  h;
    bit [3:0]  contrib;
    frame_start = fs; pix_valid = pv; pix_x = px[9:0]; pix_y = py[9:0];
    cfg_valid = cv; cfg_id = id[1:0]; cfg_en = en; cfg_cx = cx[9:0]; cfg_cy = cy[9:0];
    cfg_r = r[7:0]; cfg_color = col;
    #1;
    obs_ready = cfg_ready;
    exp_ready = m_ready && !fs;
    c = 0; h = 0;
    if (pv) eval_pixel(px, py, c, h);
    exp_rgb   = s1_v ? s1_rgb : 24'h0;
    exp_valid = s1_v;
    contrib   = (s1_v && $countones(s1_hits) >= 2) ? s1_hits : 4'b0;
    if (fs) begin
      exp_collide = m_acc | contrib;
      m_acc = 0;
    end else begin
      m_acc = m_acc | contrib;
    end
    s1_v = pv; s1_rgb = c; s1_hits = h;
    if (cv && exp_ready) begin
      m_pend[id] = '{en, cx, cy, r, col};
      m_dirty[id] = 1;
    end
    if (fs) begin
      for (int i = 0; i < 4; i++) begin
        if (m_dirty[i]) begin
          m_act[i] = m_pend[i];
          m_dirty[i] = 0;
        end
      end
    end
    m_ready = 1;
    @(posedge clk);
    #1;
    frame_start = 0; pix_valid = 0; cfg_valid = 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 24'h0);
  endtask

  task automatic pixel(input int px, input int py);
    step(0, 1, px, py, 0, 0, 0, 0, 0, 0, 24'h0);
  endtask

  task automatic write(input int id, input bit en, input int cx, input int cy, input int r,
                       input bit [23:0] col);
    step(0, 0, 0, 0, 1, id, en, cx, cy, r, col);
  endtask

  task automatic commit();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 24'h0);
  endtask

  task automatic test_reset();
    rst = 0; frame_start = 0; pix_valid = 0; pix_x = 0; pix_y = 0;
    cfg_valid = 0; cfg_id = 0; cfg_en = 0; cfg_cx = 0; cfg_cy = 0; cfg_r = 0; cfg_color = 0;
    model_reset();
    #3;
    checks++;
    if (rgb !== 24'h0 || rgb_valid !== 1'b0 || collide !== 4'h0 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state rgb=%h valid=%b collide=%b ready=%b, expected all zero",
               rgb, rgb_valid, collide, cfg_ready);
    end
    #9 rst = 1;
    idle();
    checks++;
    if (obs_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_first_edge got %b expected 0", obs_ready);
    end
    idle();
    checks++;
    if (obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_first_edge got %b expected 1", obs_ready);
    end
  endtask

  task automatic test_basic_hit();
    write(0, 1, 200, 200, 30, 24'h0000FF);
    commit();
    pixel(230, 200);
    pixel(231, 200);
    checks++;
    if (rgb !== 24'h0000FF || rgb_valid !== 1'b1) begin
      errors++;
      $display("FAIL edge_inside rgb=%h valid=%b expected 0000ff 1", rgb, rgb_valid);
    end
    idle();
    checks++;
    if (rgb !== 24'h000000 || rgb_valid !== 1'b1) begin
      errors++;
      $display("FAIL edge_outside rgb=%h valid=%b expected 000000 1", rgb, rgb_valid);
    end
    idle();
    checks++;
    if (rgb !== 24'h0 || rgb_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_zero rgb=%h valid=%b expected 000000 0", rgb, rgb_valid);
    end
  endtask

  task automatic test_priority_collide();
    write(0, 1, 100, 100, 10, 24'h0000FF);
    write(2, 1, 100, 100, 10, 24'hFF0000);
    commit();
    pixel(100, 100);
    idle();
    checks++;
    if (rgb !== 24'h0000FF) begin
      errors++;
      $display("FAIL priority rgb=%h expected 0000ff", rgb);
    end
    commit();
    checks++;
    if (collide !== 4'b0101) begin
      errors++;
      $display("FAIL collide_load got %b expected 0101", collide);
    end
    commit();
    checks++;
    if (collide !== 4'b0000) begin
      errors++;
      $display("FAIL collide_clear got %b expected 0000", collide);
    end
  endtask

  task automatic test_last_wins();
    write(1, 1, 50, 100, 5, 24'h00FF00);
    write(1, 1, 60, 100, 5, 24'h00FF00);
    pixel(60, 100);
    idle();
    checks++;
    if (rgb !== 24'h000000) begin
      errors++;
      $display("FAIL pending_not_drawn rgb=%h expected 000000", rgb);
    end
    commit();
    pixel(60, 100);
    pixel(50, 100);
    checks++;
    if (rgb !== 24'h00FF00) begin
      errors++;
      $display("FAIL last_write_drawn rgb=%h expected 00ff00", rgb);
    end
    idle();
    checks++;
    if (rgb !== 24'h000000) begin
      errors++;
      $display("FAIL first_write_dropped rgb=%h expected 000000", rgb);
    end
  endtask

  task automatic test_ready_frame_start();
    step(1, 0, 0, 0, 1, 3, 1, 300, 300, 5, 24'hFFFFFF);
    checks++;
    if (obs_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_fs got %b expected 0", obs_ready);
    end
    write(3, 1, 300, 300, 5, 24'hFFFFFF);
    checks++;
    if (obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_fs got %b expected 1", obs_ready);
    end
    pixel(300, 300);
    idle();
    checks++;
    if (rgb !== 24'h000000) begin
      errors++;
      $display("FAIL held_write_early rgb=%h expected 000000", rgb);
    end
    commit();
    pixel(300, 300);
    idle();
    checks++;
    if (rgb !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL held_write_commit rgb=%h expected ffffff", rgb);
    end
  endtask

  task automatic test_boundary();
    write(0, 1, 0, 0, 255, 24'hFFFF00);
    commit();
    pixel(639, 479);
    pixel(0, 255);
    checks++;
    if (rgb !== 24'h000000) begin
      errors++;
      $display("FAIL far_corner rgb=%h expected 000000", rgb);
    end
    pixel(255, 1);
    checks++;
    if (rgb !== 24'hFFFF00) begin
      errors++;
      $display("FAIL radius_max_edge rgb=%h expected ffff00", rgb);
    end
    idle();
    checks++;
    if (rgb !== 24'h000000) begin
      errors++;
      $display("FAIL just_outside_max rgb=%h expected 000000", rgb);
    end
  endtask

  task automatic test_reset_mid_frame();
    write(2, 1, 0, 0, 40, 24'h123456);
    write(1, 1, 0, 0, 40, 24'h00FF00);
    commit();
    pixel(0, 0);
    pixel(0, 0);
    write(0, 1, 10, 10, 50, 24'hABCDEF);
    rst = 0;
    model_reset();
    #1;
    checks++;
    if (rgb !== 24'h0 || rgb_valid !== 1'b0 || collide !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid rgb=%h valid=%b collide=%b expected all zero", rgb, rgb_valid, collide);
    end
    @(negedge clk);
    rst = 1;
    idle();
    commit();
    pixel(0, 0);
    pixel(10, 10);
    checks++;
    if (rgb !== 24'h000000 || rgb_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_bg0 rgb=%h valid=%b expected 000000 1", rgb, rgb_valid);
    end
    idle();
    checks++;
    if (rgb !== 24'h000000 || rgb_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_bg1 rgb=%h valid=%b expected 000000 1", rgb, rgb_valid);
    end
  endtask

  task automatic test_random();
    int px, py, j, r;
    bit fs, pv, cv;
    int shown = 0;
    for (int n = 0; n < 3000; n++) begin
      fs = ($urandom_range(39) == 0);
      pv = ($urandom_range(3) != 0);
      cv = ($urandom_range(3) == 0);
      j = $urandom_range(3);
      if ($urandom_range(3) == 0) begin
        px = $urandom_range(639);
        py = $urandom_range(479);
      end else begin
        r = m_act[j].r + 2;
        px = m_act[j].cx + $urandom_range(2 * r) - r;
        py = m_act[j].cy + $urandom_range(2 * r) - r;
        if (px < 0) px = 0;
        if (px > 639) px = 639;
        if (py < 0) py = 0;
        if (py > 479) py = 479;
      end
      step(fs, pv, px, py, cv, $urandom_range(3), ($urandom_range(4) != 0),
           ($urandom_range(3) == 0) ? 320 : $urandom_range(639),
           ($urandom_range(3) == 0) ? 240 : $urandom_range(479),
           $urandom_range(120), $urandom);
      checks++;
      if (rgb !== exp_rgb || rgb_valid !== exp_valid || collide !== exp_collide ||
          obs_ready !== exp_ready) begin
        errors++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random cycle %0d rgb=%h valid=%b collide=%b ready=%b expected %h %b %b %b",
                   n, rgb, rgb_valid, collide, obs_ready, exp_rgb, exp_valid, exp_collide, exp_ready);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_priority_collide();
    test_last_wins();
    test_ready_frame_start();
    test_boundary();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_object_arbiter.md
VGA_OBJECT_ARBITER -- requirements
Module: vga_object_arbiter

Interface
REQ-001 Parameter BG_COLOR, default 24'h000000: 24-bit RGB driven when no object covers the pixel.
REQ-002 Parameter NOBJ, default 4: object slot count, fixed at 4 in this revision.
REQ-003 clk  input  1  pixel clock (25 MHz domain).
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 frame_start  input  1  one-cycle pulse at start of vertical blanking.
REQ-006 pix_valid  input  1  pix_x/pix_y are an active-area pixel this cycle.
REQ-007 pix_x  input  10  active-area column, 0..639.
REQ-008 pix_y  input  10  active-area row, 0..479.
REQ-009 cfg_valid  input  1  configuration write request.
REQ-010 cfg_ready  output  1  write accepted when cfg_valid && cfg_ready.
REQ-011 cfg_id  input  2  target object slot.
REQ-012 cfg_en  input  1  slot enable.
REQ-013 cfg_cx, cfg_cy  input  10 each  circle centre.
REQ-014 cfg_r  input  8  radius.
REQ-015 cfg_color  input  24  object RGB.
REQ-016 rgb  output  24  arbitrated pixel colour.
REQ-017 rgb_valid  output  1  rgb qualifies a pixel.
REQ-018 collide  output  4  per-slot collision flags for the previous frame.

Function
REQ-019 Each slot SHALL hold a pending copy (written by cfg) and an active copy (used for drawing), plus a dirty bit.
REQ-020 An accepted write SHALL update the pending copy of cfg_id and set its dirty bit; repeated writes before commit SHALL be last-wins.
REQ-021 On frame_start, every dirty slot SHALL copy pending to active and clear dirty in that same edge; clean slots are unchanged.
REQ-022 cfg_ready SHALL be 0 in any cycle frame_start is 1, otherwise 1; commit never races a write.
REQ-023 Hit test per enabled active slot: (pix_x-cx)^2 + (pix_y-cy)^2 <= r^2, signed 11-bit differences, 22-bit unsigned sum, inclusive compare; no wrap or truncation.
REQ-024 Pipeline SHALL be exactly 2 cycles: stage 1 registers squared differences, stage 2 registers compare/priority result; rgb_valid is pix_valid delayed 2 cycles.
REQ-025 Priority: lowest hitting slot index wins; no hit gives BG_COLOR; rgb SHALL be 0 whenever rgb_valid is 0.
REQ-026 A pixel with 2 or more hits SHALL set all hitting slots' bits in a sticky collision accumulator.
REQ-027 On frame_start, collide SHALL load the accumulator (including any hit resolved that same cycle) and the accumulator SHALL clear.
REQ-028 Active copies SHALL NOT change while pix_valid pixels are in flight except at frame_start.

Reset
REQ-029 On rst low: all slots disabled, pending/active fields and dirty bits 0, pipeline cleared, rgb=0, rgb_valid=0, collide=0, accumulator=0, cfg_ready=0.
REQ-030 cfg_ready SHALL rise the first clk edge after rst deasserts; reset mid-frame discards pending writes.

Structure
REQ-031 Package vga_pkg SHALL hold H_ACT=640, V_ACT=480, NOBJ, the object-record typedef (en, cx, cy, r, color) and BG_COLOR default.
REQ-032 One sub-module vga_circle_hit (one slot, 2-stage hit test) SHALL be instantiated NOBJ times.

Verification
REQ-033 Slot0 en, centre (200,200), r=30, blue, commit; pixel (230,200) -> rgb 0000FF after 2 cycles; (231,200) -> BG_COLOR.
REQ-034 Slot0 blue and slot2 red both at (100,100) r=10; pixel (100,100) -> 0000FF; collide=0101 after next frame_start.
REQ-035 Write slot1 cx=50 then cx=60 before frame_start; drawing unchanged until frame_start, then uses cx=60.
REQ-036 cfg_valid held during frame_start cycle -> cfg_ready 0, write accepted next cycle, commits only at the following frame_start.
REQ-037 Slot at (0,0) r=255, pixel (639,479) -> no hit, no overflow false-positive; pixel (0,255) -> hit.
REQ-038 Assert rst low mid-frame with enabled slots -> rgb, rgb_valid, collide 0 immediately; all pixels BG after release until new commit.
